// File: rtl/reg_map_arbiter.sv
// Two-port arbiter in front of the register_map access port: serialises port A
// (SPI slave) and port B (on-chip requester) through an IDLE/ACCESS/RESP FSM.
module reg_map_arbiter #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_STREAK = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_n,
  input  logic                  a_req_i,
  input  logic                  a_we_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_wdata_i,
  output logic                  a_ack_o,
  output logic [DATA_WIDTH-1:0] a_rdata_o,
  input  logic                  b_req_i,
  input  logic                  b_we_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_wdata_i,
  output logic                  b_ack_o,
  output logic [DATA_WIDTH-1:0] b_rdata_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic                  write_en_o,
  output logic                  read_en_o,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX_C = 4'(MAX_STREAK);

  state_t                  state_r,       state_nxt_s;
  logic [3:0]              streak_r,      streak_nxt_s;
  logic                    we_r,          we_nxt_s;
  logic                    id_r,          id_nxt_s;
  logic [ADDR_WIDTH-1:0]   addr_r,        addr_nxt_s;
  logic [DATA_WIDTH-1:0]   wdata_r,       wdata_nxt_s;
  logic                    write_en_r,    write_en_nxt_s;
  logic                    read_en_r,     read_en_nxt_s;
  logic                    a_ack_r,       a_ack_nxt_s;
  logic                    b_ack_r,       b_ack_nxt_s;
  logic [DATA_WIDTH-1:0]   a_rdata_r,     a_rdata_nxt_s;
  logic [DATA_WIDTH-1:0]   b_rdata_r,     b_rdata_nxt_s;
  logic                    busy_r,        busy_nxt_s;

  logic                    grant_b_s;
  logic                    sel_we_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [DATA_WIDTH-1:0]   sel_wdata_s;
  logic [3:0]              streak_inc_s;

  // B wins when alone, or when A has used up its streak allowance while B waits
  assign grant_b_s    = b_req_i & (~a_req_i | (streak_r == STREAK_MAX_C));
  assign sel_we_s     = grant_b_s ? b_we_i    : a_we_i;
  assign sel_addr_s   = grant_b_s ? b_addr_i  : a_addr_i;
  assign sel_wdata_s  = grant_b_s ? b_wdata_i : a_wdata_i;
  assign streak_inc_s = (streak_r == 4'hF) ? streak_r : (streak_r + 4'd1);

  // Next-state and next-output computation; every output is registered below
  always_comb begin
    state_nxt_s    = state_r;
    streak_nxt_s   = streak_r;
    we_nxt_s       = we_r;
    id_nxt_s       = id_r;
    addr_nxt_s     = addr_r;
    wdata_nxt_s    = wdata_r;
    write_en_nxt_s = 1'b0;
    read_en_nxt_s  = 1'b0;
    a_ack_nxt_s    = 1'b0;
    b_ack_nxt_s    = 1'b0;
    a_rdata_nxt_s  = a_rdata_r;
    b_rdata_nxt_s  = b_rdata_r;

    case (state_r)
      ST_IDLE: begin
        if (a_req_i | b_req_i) begin
          state_nxt_s    = ST_ACCESS;
          id_nxt_s       = grant_b_s;
          we_nxt_s       = sel_we_s;
          addr_nxt_s     = sel_addr_s;
          wdata_nxt_s    = sel_we_s ? sel_wdata_s : wdata_r;
          write_en_nxt_s = sel_we_s;
          read_en_nxt_s  = ~sel_we_s;
          // Only A grants taken against a waiting B build up the streak
          if (grant_b_s) begin
            streak_nxt_s = 4'd0;
          end else if (b_req_i) begin
            streak_nxt_s = streak_inc_s;
          end else begin
            streak_nxt_s = 4'd0;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_nxt_s   = ST_RESP;
        a_ack_nxt_s   = ~id_r;
        b_ack_nxt_s   = id_r;
        a_rdata_nxt_s = (~we_r & ~id_r) ? read_data_i : a_rdata_r;
        b_rdata_nxt_s = (~we_r &  id_r) ? read_data_i : b_rdata_r;
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State and output registers; reset aborts any access and clears all outputs
  always_ff @(posedge clk_i or negedge rstn_n) begin
    if (!rstn_n) begin
      state_r    <= ST_IDLE;
      streak_r   <= 4'd0;
      we_r       <= 1'b0;
      id_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      write_en_r <= 1'b0;
      read_en_r  <= 1'b0;
      a_ack_r    <= 1'b0;
      b_ack_r    <= 1'b0;
      a_rdata_r  <= '0;
      b_rdata_r  <= '0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      streak_r   <= streak_nxt_s;
      we_r       <= we_nxt_s;
      id_r       <= id_nxt_s;
      addr_r     <= addr_nxt_s;
      wdata_r    <= wdata_nxt_s;
      write_en_r <= write_en_nxt_s;
      read_en_r  <= read_en_nxt_s;
      a_ack_r    <= a_ack_nxt_s;
      b_ack_r    <= b_ack_nxt_s;
      a_rdata_r  <= a_rdata_nxt_s;
      b_rdata_r  <= b_rdata_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

  assign addr_o       = addr_r;
  assign write_data_o = wdata_r;
  assign write_en_o   = write_en_r;
  assign read_en_o    = read_en_r;
  assign a_ack_o      = a_ack_r;
  assign b_ack_o      = b_ack_r;
  assign a_rdata_o    = a_rdata_r;
  assign b_rdata_o    = b_rdata_r;
  assign busy_o       = busy_r;

endmodule

// File: tb/tb_reg_map_arbiter.sv
// Scoreboard bench for reg_map_arbiter: expected accesses are queued when the
// requesters drive them and checked against the strobes and acks the DUT emits.
module tb_reg_map_arbiter;

  logic       clk_i = 1'b0;
  logic       rstn_n = 1'b0;
  logic       a_req_i = 1'b0, a_we_i = 1'b0;
  logic [6:0] a_addr_i = 7'd0;
  logic [7:0] a_wdata_i = 8'd0;
  logic       a_ack_o;
  logic [7:0] a_rdata_o;
  logic       b_req_i = 1'b0, b_we_i = 1'b0;
  logic [6:0] b_addr_i = 7'd0;
  logic [7:0] b_wdata_i = 8'd0;
  logic       b_ack_o;
  logic [7:0] b_rdata_o;
  logic [6:0] addr_o;
  logic [7:0] write_data_o;
  logic       write_en_o, read_en_o;
  logic [7:0] read_data_i;
  logic       busy_o;

  reg_map_arbiter #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .MAX_STREAK(4)) dut (
    .clk_i(clk_i), .rstn_n(rstn_n),
    .a_req_i(a_req_i), .a_we_i(a_we_i), .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i),
    .a_ack_o(a_ack_o), .a_rdata_o(a_rdata_o),
    .b_req_i(b_req_i), .b_we_i(b_we_i), .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i),
    .b_ack_o(b_ack_o), .b_rdata_o(b_rdata_o),
    .addr_o(addr_o), .write_data_o(write_data_o), .write_en_o(write_en_o),
    .read_en_o(read_en_o), .read_data_i(read_data_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit         port;   // 0 = A, 1 = B
    bit         we;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  logic [7:0] mem [0:127];
  logic [7:0] exp_mem [0:127];
  logic [7:0] last_rd [0:1];
  int         n_vec = 0;
  int         n_miss = 0;
  int         cyc = 0;
  int         last_strobe_cyc = 0;
  bit         ack_due = 1'b0;
  bit         idle_due = 1'b0;
  bit         contention = 1'b0;
  bit         have_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void push(input bit port, input bit we, input logic [6:0] addr,
                               input logic [7:0] wd);
    exp_t e;
    e.port  = port;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wd;
    e.rdata = exp_mem[addr];
    if (we) exp_mem[addr] = wd;
    sb.push_back(e);
  endfunction

  // register_map model: combinational read, write on the strobe edge
  assign read_data_i = mem[addr_o];
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'(i * 7 + 1);
    mem[13] = 8'h3C;
    forever begin
      @(posedge clk_i);
      if (write_en_o) mem[addr_o] <= write_data_o;
    end
  end

  // Output monitor: strobes pop the scoreboard, acks follow exactly one cycle later
  initial begin
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rstn_n) begin
        ack_due    = 1'b0;
        idle_due   = 1'b0;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
      end else begin
        if (idle_due) begin
          check("busy_gap", {31'd0, busy_o}, 32'd0);
          idle_due = 1'b0;
        end
        if (ack_due) begin
          check("ack_port", {30'd0, a_ack_o, b_ack_o}, cur.port ? 32'd1 : 32'd2);
          check("busy_resp", {31'd0, busy_o}, 32'd1);
          if (!cur.we) last_rd[cur.port] = cur.rdata;
          check("a_rdata", {24'd0, a_rdata_o}, {24'd0, last_rd[0]});
          check("b_rdata", {24'd0, b_rdata_o}, {24'd0, last_rd[1]});
          ack_due  = 1'b0;
          idle_due = 1'b1;
        end else if (a_ack_o | b_ack_o) begin
          check("spurious_ack", 32'd1, 32'd0);
        end
        if (write_en_o | read_en_o) begin
          check("strobe_excl", {31'd0, write_en_o & read_en_o}, 32'd0);
          check("busy_access", {31'd0, busy_o}, 32'd1);
          if (sb.size() == 0) begin
            check("unexpected_access", 32'd1, 32'd0);
          end else begin
            cur = sb.pop_front();
            check("access_we", {31'd0, write_en_o}, {31'd0, cur.we});
            check("access_addr", {25'd0, addr_o}, {25'd0, cur.addr});
            if (cur.we) check("access_wdata", {24'd0, write_data_o}, {24'd0, cur.wdata});
            ack_due = 1'b1;
          end
          if (contention && have_prev) check("throughput", cyc - last_strobe_cyc, 32'd3);
          last_strobe_cyc = cyc;
          have_prev       = contention;
        end
      end
    end
  end

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [6:0] addr, input logic [7:0] wd);
    if (port) begin
      b_req_i = req; b_we_i = we; b_addr_i = addr; b_wdata_i = wd;
    end else begin
      a_req_i = req; a_we_i = we; a_addr_i = addr; a_wdata_i = wd;
    end
  endtask

  // One request on an otherwise idle arbiter; ack must arrive two cycles after sampling
  task automatic do_single(input bit port, input bit we, input logic [6:0] addr,
                           input logic [7:0] wd);
    int n;
    bit seen;
    @(negedge clk_i);
    drive(port, 1'b1, we, addr, wd);
    push(port, we, addr, wd);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk_i);
      n++;
      if (port ? b_ack_o : a_ack_o) seen = 1'b1;
    end
    check("ack_latency", n, 32'd2);
    @(negedge clk_i);
    drive(port, 1'b0, we, addr, wd);
  endtask

  // Both ports request continuously: A writes wd to 0x10, B reads 0x10
  task automatic run_both(input int n, input logic [7:0] wd);
    int cnt;
    int t;
    for (int k = 0; k < n; k++) begin
      if (k % 5 == 4) push(1'b1, 1'b0, 7'h10, 8'h00);
      else            push(1'b0, 1'b1, 7'h10, wd);
    end
    @(negedge clk_i);
    contention = 1'b1;
    have_prev  = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 7'h10, wd);
    drive(1'b1, 1'b1, 1'b0, 7'h10, 8'h00);
    cnt = 0;
    t = 0;
    while (cnt < n && t < 200) begin
      @(negedge clk_i);
      t++;
      if (a_ack_o | b_ack_o) cnt++;
    end
    a_req_i    = 1'b0;
    b_req_i    = 1'b0;
    contention = 1'b0;
    check("both_ack_count", cnt, n);
  endtask

  initial begin
    int n;
    bit seen;
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    for (int i = 0; i < 128; i++) exp_mem[i] = 8'(i * 7 + 1);
    exp_mem[13] = 8'h3C;

    repeat (3) @(negedge clk_i);
    check("rst_a_ack", {31'd0, a_ack_o}, 32'd0);
    check("rst_b_ack", {31'd0, b_ack_o}, 32'd0);
    check("rst_strobes", {30'd0, write_en_o, read_en_o}, 32'd0);
    check("rst_addr", {25'd0, addr_o}, 32'd0);
    check("rst_wdata", {24'd0, write_data_o}, 32'd0);
    check("rst_rdata", {a_rdata_o, b_rdata_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    rstn_n = 1'b1;

    do_single(1'b0, 1'b1, 7'h05, 8'hA5);
    do_single(1'b1, 1'b0, 7'h0D, 8'h00);
    do_single(1'b0, 1'b0, 7'h05, 8'h00);

    run_both(10, 8'h77);

    do_single(1'b0, 1'b1, 7'h30, 8'h11);
    do_single(1'b0, 1'b1, 7'h31, 8'h22);
    run_both(5, 8'h44);

    // A drops its request while its access is already in flight
    @(negedge clk_i);
    drive(1'b0, 1'b1, 1'b0, 7'h31, 8'h00);
    push(1'b0, 1'b0, 7'h31, 8'h00);
    @(negedge clk_i);
    a_req_i = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk_i);
      n++;
      if (a_ack_o) seen = 1'b1;
    end
    check("withdrawn_ack", {31'd0, seen}, 32'd1);

    // A glitches its request during B's access without spanning a clock edge
    @(negedge clk_i);
    drive(1'b1, 1'b1, 1'b1, 7'h20, 8'h5B);
    push(1'b1, 1'b1, 7'h20, 8'h5B);
    @(posedge clk_i);
    #2 a_req_i = 1'b1;
    #1 a_req_i = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk_i);
      n++;
      if (b_ack_o) seen = 1'b1;
    end
    check("glitch_b_ack", {31'd0, seen}, 32'd1);
    @(negedge clk_i);
    b_req_i = 1'b0;
    repeat (5) @(negedge clk_i);

    // Reset asserted in the middle of an A write to 0x02
    drive(1'b0, 1'b1, 1'b1, 7'h02, 8'h99);
    @(posedge clk_i);
    #2;
    check("pre_rst_we", {31'd0, write_en_o}, 32'd1);
    rstn_n = 1'b0;
    #1;
    check("rst_mid_we", {31'd0, write_en_o}, 32'd0);
    check("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    check("rst_mid_acks", {30'd0, a_ack_o, b_ack_o}, 32'd0);
    a_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rstn_n = 1'b1;
    repeat (3) @(negedge clk_i);
    do_single(1'b0, 1'b0, 7'h0D, 8'h00);

    repeat (5) @(negedge clk_i);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/reg_map_arbiter.md
Name: reg_map_arbiter

Overview:
- Shares the single register_map access port between two requesters.
- Port A: SPI slave memory interface, the default-priority side.
- Port B: on-chip requester, e.g. a status/config sequencer.
- Serialises accesses through a 3-state FSM with a fixed-priority-plus-anti-starvation policy, drives register_map addr/write/read strobes, and returns read data and a one-cycle ack per request.

Parameters:
- ADDR_WIDTH, 7, register address width.
- DATA_WIDTH, 8, register data width.
- MAX_STREAK, 4, max consecutive A grants while B is pending before B is forced to win (legal range 1..15).

Ports:
- clk_i  in  1  system clock, rising edge.
- rstn_n  in  1  asynchronous active-low reset.
- a_req_i  in  1  port A request, held until a_ack_o.
- a_we_i  in  1  port A write (1) / read (0).
- a_addr_i  in  ADDR_WIDTH  port A address.
- a_wdata_i  in  DATA_WIDTH  port A write data.
- a_ack_o  out  1  port A completion pulse.
- a_rdata_o  out  DATA_WIDTH  port A read data.
- b_req_i, b_we_i, b_addr_i, b_wdata_i, b_ack_o, b_rdata_o: same as port A, for port B.
- addr_o  out  ADDR_WIDTH  register_map address.
- write_data_o  out  DATA_WIDTH  register_map write data.
- write_en_o  out  1  register_map write strobe.
- read_en_o  out  1  register_map read strobe.
- read_data_i  in  DATA_WIDTH  register_map read data, combinational from addr_o.
- busy_o  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rstn_n is asynchronous, active-low.
- On reset assertion:
  - FSM goes to IDLE; streak counter clears to 0.
  - All outputs go to 0: acks, strobes, addr_o, write_data_o, rdata, busy_o.
  - Any in-flight access is aborted: no ack, no strobe.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high at the clock edge, select a winner.
  - Latch the winner's we/addr/wdata and winner id into internal registers; go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (exactly 1 cycle):
  - addr_o = latched addr.
  - If we: write_data_o = latched wdata and write_en_o = 1.
  - Else read_en_o = 1; read_data_i is captured at the closing edge into the winner's rdata register.
  - Go to RESP.
- RESP (exactly 1 cycle):
  - The winner's ack_o is 1; the other ack stays 0.
  - Go to IDLE.
- Timing:
  - Latency from req sampled in IDLE to ack high is 2 cycles.
  - Throughput is one access per 3 cycles.
- Arbitration, evaluated in IDLE only:
  - A only: A wins.
  - B only: B wins.
  - Both, streak < MAX_STREAK: A wins.
  - Both, streak == MAX_STREAK: B wins.
- Streak counter:
  - Increments, saturating, on each A grant made while b_req_i is high.
  - Clears on any B grant, and on any A grant with b_req_i low.
- Requester handshake rules:
  - Hold req and the payload stable until ack is seen; drop req in the cycle after ack.
  - A req seen in IDLE after RESP is treated as a new request.
  - Payload is latched at grant, so later changes do not affect the access.
  - Dropping req after grant does not cancel the access; ack still pulses.
  - Dropping req before grant is legal and has no effect.
- Output hold rules:
  - rdata_o of each port holds its last read value until the next read completes on that port.
  - Writes leave rdata_o unchanged.
  - addr_o and write_data_o may hold their last values outside ACCESS.
  - Strobes are exactly 1 cycle wide, mutually exclusive, and only asserted in ACCESS.
- Reset mid-ACCESS: the strobe drops immediately (asynchronously). A write may or may not have been taken by register_map at an edge that coincides with reset release; the bench must not check that case.

Test Plan:
- Single A write: a_req=1, we=1, addr=0x05, wdata=0xA5. Expect write_en_o=1 with addr_o=0x05, write_data_o=0xA5 one cycle after sample; a_ack_o pulse the next cycle; b_ack_o stays 0.
- Single B read: register model returns 0x3C at addr 0x0D. Expect read_en_o one cycle, b_rdata_o=0x3C when b_ack_o=1; a_rdata_o unchanged.
- Contention: A and B both request continuously, MAX_STREAK=4. Grant order A,A,A,A,B,A,A,A,A,B; no two strobes ever overlap; busy_o low only for 1 cycle between accesses.
- Streak reset: A×2 with B idle, then both request. B wins only after 4 further A grants; a streak count of 2 taken while B was idle does not count.
- Req withdrawn:
  - a_req drops in the ACCESS cycle: access completes, ack pulses.
  - a_req pulses for 0 cycles while the FSM is in ACCESS for B: no A access results.
- Async reset in ACCESS (write to 0x02): write_en_o, busy_o and acks go to 0 within the same cycle, no ack follows, FSM is IDLE after release, and a fresh A read completes normally with 2-cycle latency.
